// File: rtl/ps2_cmd_ctl.sv
// ps2_cmd_ctl: host-side command sequencer placed in front of ps2_send.
//
// Two requesters share the PS/2 transmit path. The arbiter alternates
// between them when both are active. The granted command byte goes to
// ps2_send. The controller then waits for the device response. On a
// resend (0xFE) it transmits the same byte again. The granted requester
// gets a one-cycle done pulse together with a status code.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   req0/cmd0  requester 0 request level and command byte
//   done0      one-cycle completion pulse to requester 0
//   req1/cmd1  requester 1 request level and command byte
//   done1      one-cycle completion pulse to requester 1
//   err        status, valid with doneN: 00 ok, 01 retries exhausted, 10 timeout
//   ctl_busy   high whenever the sequencer is not idle
//   send       one-cycle start pulse to ps2_send
//   code       byte to ps2_send, held from SEND until the return to IDLE
//   tx_busy    ps2_send is transmitting
//   tx_rdy     ps2_send is idle and can accept a byte
//   rx_strobe  valid pulse from the PS/2 receiver
//   rx_code    received byte, valid with rx_strobe
//
// CNT_W must satisfy 2**CNT_W > ACK_TIMEOUT.
module ps2_cmd_ctl #(
   parameter int MAX_RETRY   = 3,
   parameter int ACK_TIMEOUT = 250000,
   parameter int CNT_W       = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] cmd0,
   output logic       done0,
   input  logic       req1,
   input  logic [7:0] cmd1,
   output logic       done1,
   output logic [1:0] err,
   output logic       ctl_busy,
   output logic       send,
   output logic [7:0] code,
   input  logic       tx_busy,
   input  logic       tx_rdy,
   input  logic       rx_strobe,
   input  logic [7:0] rx_code
);

   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [CNT_W-1:0] T_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [RW-1:0]    R_MAX  = RW'(MAX_RETRY);

   localparam logic [7:0] BYTE_ACK    = 8'hFA;
   localparam logic [7:0] BYTE_RESEND = 8'hFE;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_RETRY   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      SEND,
      WAIT_BUSY,
      WAIT_DONE,
      WAIT_ACK,
      FINISH
   } state_t;

   state_t           state;
   logic             gnt;        // 0 = requester 0, 1 = requester 1
   logic             rr_last;    // last granted requester, drives tie-break
   logic [RW-1:0]    retry_cnt;
   logic [CNT_W-1:0] timer;

   // NOTE: every register here is assigned with <= so that all of them
   // update together on the clock edge, whatever the order of the statements.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         rr_last   <= 1'b1;
         retry_cnt <= '0;
         timer     <= '0;
         send      <= 1'b0;
         code      <= 8'h00;
         done0     <= 1'b0;
         done1     <= 1'b0;
         err       <= ERR_OK;
         ctl_busy  <= 1'b0;
      end else begin
         // Pulse outputs default low here. Each state then raises only the
         // pulses it needs for exactly one cycle.
         send  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;

         case (state)
            IDLE: begin
               if ((req0 | req1) & tx_rdy) begin
                  if (req0 & req1) begin
                     // Tie: the requester that was not served last wins.
                     gnt  <= ~rr_last;
                     code <= rr_last ? cmd0 : cmd1;
                  end else if (req0) begin
                     gnt  <= 1'b0;
                     code <= cmd0;
                  end else begin
                     gnt  <= 1'b1;
                     code <= cmd1;
                  end
                  retry_cnt <= '0;
                  ctl_busy  <= 1'b1;
                  state     <= GRANT;
               end
            end

            GRANT: begin
               rr_last <= gnt;
               send    <= 1'b1;      // send is high during SEND
               state   <= SEND;
            end

            SEND: begin
               timer <= '0;
               state <= WAIT_BUSY;
            end

            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (timer == T_LAST) begin
                  err   <= ERR_TIMEOUT;
                  done0 <= ~gnt;
                  done1 <= gnt;
                  state <= FINISH;
               end else begin
                  timer <= timer + 1'b1;  // stops at T_LAST, so it never wraps
               end
            end

            WAIT_DONE: begin
               // ps2_send bounds its own frame time, so there is no timeout here.
               if (!tx_busy) begin
                  timer <= '0;
                  state <= WAIT_ACK;
               end
            end

            WAIT_ACK: begin
               // A received byte takes priority over a timeout in the same cycle.
               if (rx_strobe && rx_code == BYTE_ACK) begin
                  err   <= ERR_OK;
                  done0 <= ~gnt;
                  done1 <= gnt;
                  state <= FINISH;
               end else if (rx_strobe && rx_code == BYTE_RESEND) begin
                  if (retry_cnt < R_MAX) begin
                     retry_cnt <= retry_cnt + 1'b1;
                     send      <= 1'b1;
                     state     <= SEND;
                  end else begin
                     err   <= ERR_RETRY;
                     done0 <= ~gnt;
                     done1 <= gnt;
                     state <= FINISH;
                  end
               end else if (timer == T_LAST) begin
                  err   <= ERR_TIMEOUT;
                  done0 <= ~gnt;
                  done1 <= gnt;
                  state <= FINISH;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            FINISH: begin
               ctl_busy <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               ctl_busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
